rr_mux4x1_stream: RTL and testbench
===================================

Name: rr_mux4x1_stream

Overview:
- 4-to-1 registered stream multiplexer. It merges four valid/ready input channels onto one output channel using round-robin arbitration.
- It is the gather side of the 1-to-4 demux datapath: the demux fans one stream out to four lanes, and this block collects the lanes back.
- One output register stage; sustains one beat per clock.

Parameters:
- DATA_W, 8, width of each data beat.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_data, input, 4*DATA_W, channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid, input, 4, per-channel beat valid.
- in_ready, output, 4, per-channel beat accepted (combinational).
- in_last, input, 4, per-channel end-of-packet; used only when MUX4_PKT_LOCK_EN is defined.
- out_data, output, DATA_W, registered output beat.
- out_valid, output, 1, registered output valid.
- out_ready, input, 1, downstream ready.
- out_sel, output, 2, index of the source channel of the current out_data.
- out_last, output, 1, registered copy of in_last of the accepted beat; constant 0 when the macro is undefined.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_sel=0, out_last=0, rr_ptr=3 (so channel 0 has top priority first), FSM=ARB.
- Load enable: load = ~out_valid | out_ready.
- Arbitration: combinational over in_valid.
  - Priority order is rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr (mod 4, wraps 3->0).
  - The first valid channel in that order is the winner.
- in_ready[i] = load & (winner==i) & in_valid[i]. At most one bit is set per cycle.
- Accept (any in_ready[i]=1):
  - Next edge: out_data<=in_data[i], out_sel<=i, out_last<=in_last[i] (macro only), out_valid<=1, rr_ptr<=i.
- Latency: accept at edge N gives out_valid=1 with that beat after edge N.
- Back-to-back throughput: 1 beat/cycle while out_ready=1.
- No accept and out_ready=1 with out_valid=1: out_valid<=0 (output drains). out_data, out_sel and rr_ptr hold.
- Stall: out_valid=1 and out_ready=0.
  - in_ready=0 on all channels.
  - out_data, out_sel and out_last are stable.
  - rr_ptr is frozen.
- All in_valid=0: no accept; rr_ptr unchanged.
- Simultaneous requests: exactly one winner. A channel continuously asserting valid waits at most 3 beats for a grant.
- Simultaneous out_ready consume and new accept in the same cycle: the register reloads. out_valid stays 1 with no bubble.
- in_valid may change while in_ready=0. The block never samples in_data without in_ready.
- Reset mid-operation: a held beat is discarded; no output activity until the first accept after release.
- FSM: ARB always (LOCK is unreachable) unless the macro is defined.

Optional Feature:
- Macro MUX4_PKT_LOCK_EN: packet-atomic arbitration.
- Defined: two-state FSM.
  - ARB: normal round-robin. On an accept from channel i with in_last[i]=0, go to LOCK with lock_ch=i.
  - LOCK: winner is forced to lock_ch; other channels get in_ready=0 even if valid. An accept from lock_ch with in_last=1 returns to ARB.
  - rr_ptr updates on each accept as normal (it equals lock_ch while locked).
  - Single-beat packets (in_last=1 on the first beat) stay in ARB.
  - out_last is the registered in_last of the accepted beat.
  - Reset forces ARB.
- Undefined: in_last is ignored, out_last is tied to 0, and arbitration is per beat.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_sel and out_last read 0 immediately (async). After release with in_valid=4'b0001, in_data ch0=8'hA5 -> in_ready=4'b0001 and, after one edge, out_data=8'hA5, out_sel=0, out_valid=1.
- Fairness: all in_valid=1 continuously (data ch0..ch3 = 8'h10, 8'h21, 8'h32, 8'h43), out_ready=1 -> out_sel sequence 0,1,2,3,0,1 with matching data and no bubbles.
- Backpressure: out_valid=1, out_data=8'h21, out_ready=0 for 3 cycles with all channels valid -> in_ready=0, output stable. First cycle with out_ready=1 -> ch2 accepted same cycle; next edge out_data=8'h32, out_valid stays 1.
- Sparse/wrap: rr_ptr=3 (after a ch3 grant), in_valid=4'b1000 only -> ch3 granted again. Then in_valid=4'b1001 -> ch0 granted before ch3.
- Drain: single beat from ch1, then in_valid=0, out_ready=1 -> out_valid=1 for exactly one cycle then 0; out_sel holds 1.
- MUX4_PKT_LOCK_EN: ch1 sends 3 beats (in_last=0,0,1) while ch2 is continuously valid -> out_sel=1,1,1 then 2; out_last=0,0,1,x. Without the macro the same stimulus interleaves 1,2,1,2,… and out_last=0.

Source files
------------

// File: rtl/rr_mux4x1_stream.sv
// rr_mux4x1_stream: four valid/ready lanes merged onto one registered stream
// with round-robin arbitration; optional packet lock via MUX4_PKT_LOCK_EN.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   in_data[4*DATA_W]  lane i at [i*DATA_W +: DATA_W]
//   in_valid/in_ready  per-lane handshake (in_ready combinational)
//   in_last            per-lane end-of-packet (lock build only)
//   out_data/out_valid registered output beat
//   out_ready          downstream ready
//   out_sel            source lane of out_data
//   out_last           registered in_last of the beat (0 without the macro)
//
// Macro MUX4_PKT_LOCK_EN: hold the grant on one lane until its in_last beat.

module rr_mux4x1_stream #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DATA_W-1:0] in_data,
  input  logic [3:0]          in_valid,
  output logic [3:0]          in_ready,
  input  logic [3:0]          in_last,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          out_sel,
  output logic                out_last
);

`ifdef MUX4_PKT_LOCK_EN
  localparam logic PKT_LOCK = 1'b1;
`else
  localparam logic PKT_LOCK = 1'b0;
`endif

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] rr_ptr;
  logic [1:0] win;
  logic [1:0] cand;
  logic       win_vld;
  logic       load;
  logic       acc;

  assign load = ~out_valid | out_ready;

  // Scan lowest priority first so the highest-priority
  // valid lane (rr_ptr+1) is the last one written.
  // While locked, rr_ptr already holds the locked lane.
  always_comb begin
    win     = rr_ptr;
    win_vld = 1'b0;
    cand    = rr_ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = rr_ptr + 2'(k);
      if (in_valid[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
    if (state == LOCK) begin
      win     = rr_ptr;
      win_vld = in_valid[rr_ptr];
    end
  end

  assign acc      = load & win_vld;
  assign in_ready = acc ? (4'b0001 << win) : 4'b0000;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ARB: begin
        if (acc && PKT_LOCK && !in_last[win])
          state_nxt = LOCK;
      end
      LOCK: begin
        if (acc && in_last[win])
          state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      rr_ptr    <= 2'd3;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sel   <= 2'd0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        out_data  <= in_data[int'(win)*DATA_W +: DATA_W];
        out_sel   <= win;
        out_last  <= PKT_LOCK & in_last[win];
        out_valid <= 1'b1;
        rr_ptr    <= win;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux4x1_stream.sv
// tb_rr_mux4x1_stream: scoreboard bench for rr_mux4x1_stream
// directed plan items followed by randomized traffic.

module tb_rr_mux4x1_stream;

`ifdef MUX4_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [3:0]  in_last;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_sel;
  logic        out_last;

  rr_mux4x1_stream #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [1:0] s;
    logic       l;
  } beat_t;

  beat_t q[$];
  int checks = 0;
  int passes = 0;

  // reference model state
  int m_ptr    = 3;
  bit m_full   = 0;
  bit m_locked = 0;
  int m_lock   = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h @%0t",
                  name, act, exp, $time);
  endtask

  // Model: predicts the accept for the coming edge and
  // enqueues the beat it must produce.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ptr    = 3;
      m_full   = 0;
      m_locked = 0;
      m_lock   = 0;
    end else begin
      int  w;
      bit  ld;
      logic [3:0] exp_rdy;
      beat_t b;
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
      ld = !m_full || out_ready;
      w  = -1;
      if (m_locked) begin
        if (in_valid[m_lock]) w = m_lock;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_ptr + k) % 4;
          if (w < 0 && in_valid[c]) w = c;
        end
      end
      exp_rdy = 4'b0000;
      if (ld && w >= 0) exp_rdy[w] = 1'b1;
      chk("in_ready", {28'd0, in_ready}, {28'd0, exp_rdy});
      if (ld && w >= 0) begin
        b.d = in_data[w*8 +: 8];
        b.s = w[1:0];
        b.l = LOCK_EN ? in_last[w] : 1'b0;
        q.push_back(b);
        m_ptr  = w;
        m_full = 1;
        if (LOCK_EN) begin
          m_locked = !in_last[w];
          m_lock   = w;
        end
      end else if (out_ready) begin
        m_full = 0;
      end
    end
  end

  // Monitor: compares each beat leaving the DUT.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat: got sel %0d data %0h expected none",
                 out_sel, out_data);
      end else begin
        beat_t e;
        e = q.pop_front();
        chk("out_data", {24'd0, out_data}, {24'd0, e.d});
        chk("out_sel", {30'd0, out_sel}, {30'd0, e.s});
        chk("out_last", {31'd0, out_last}, {31'd0, e.l});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [7:0] d);
    in_data[c*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = '0;
    in_last   = 4'hF;
    out_ready = 1'b1;
    do_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sel", {30'd0, out_sel}, 32'd0);

    // fairness from reset: 0,1,2,3,0,1
    set_ch(0, 8'h10);
    set_ch(1, 8'h21);
    set_ch(2, 8'h32);
    set_ch(3, 8'h43);
    in_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fair_sel", {30'd0, out_sel}, k % 4);
      chk("fair_data", {24'd0, out_data}, 8'h10 + 8'h11 * (k % 4));
      chk("fair_valid", {31'd0, out_valid}, 32'd1);
    end

    // backpressure holding 8'h21
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", {28'd0, in_ready}, 32'd0);
      chk("bp_data", {24'd0, out_data}, 32'h21);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {28'd0, in_ready}, 32'b0100);
    step();
    chk("bp_next_data", {24'd0, out_data}, 32'h32);
    chk("bp_next_valid", {31'd0, out_valid}, 32'd1);

    // sparse / wrap
    in_valid = 4'b1000;
    step();
    chk("wrap_sel3", {30'd0, out_sel}, 32'd3);
    #1;
    chk("wrap_again", {28'd0, in_ready}, 32'b1000);
    step();
    in_valid = 4'b1001;
    #1;
    chk("wrap_ch0_first", {28'd0, in_ready}, 32'b0001);
    step();
    chk("wrap_sel0", {30'd0, out_sel}, 32'd0);

    // drain after a single ch1 beat
    in_valid = 4'b0010;
    set_ch(1, 8'h5C);
    step();
    in_valid = 4'b0000;
    chk("drain_valid1", {31'd0, out_valid}, 32'd1);
    step();
    chk("drain_valid0", {31'd0, out_valid}, 32'd0);
    chk("drain_sel_hold", {30'd0, out_sel}, 32'd1);
    step();
    chk("drain_still0", {31'd0, out_valid}, 32'd0);

    // ch1 three-beat packet against continuous ch2
    begin
      int idx;
      int cyc;
      bit got;
      idx = 0;
      cyc = 0;
      set_ch(2, 8'hC2);
      while (idx < 3 && cyc < 50) begin
        in_valid = 4'b0110;
        set_ch(1, 8'hB0 + 8'(idx));
        in_last = {2'b01, (idx == 2), 1'b1};
        #1;
        got = in_ready[1];
        step();
        if (got) idx++;
        cyc++;
      end
      if (cyc >= 50) begin
        checks++;
        $display("FAIL pkt_timeout: got %0d beats expected 3", idx);
      end
      in_valid = 4'b0000;
      in_last  = 4'hF;
      step();
      step();
    end

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // reset in the middle of a held beat
    in_last   = 4'hF;
    in_valid  = 4'hF;
    out_ready = 1'b0;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", {24'd0, out_data}, 32'd0);
    chk("arst_sel", {30'd0, out_sel}, 32'd0);
    chk("arst_last", {31'd0, out_last}, 32'd0);
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    set_ch(0, 8'hA5);
    in_valid = 4'b0001;
    #1;
    chk("post_rst_ready", {28'd0, in_ready}, 32'b0001);
    step();
    chk("post_rst_data", {24'd0, out_data}, 32'hA5);
    chk("post_rst_sel", {30'd0, out_sel}, 32'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 4'b0000;
    step();
    step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
